// File: rtl/id_pkg.sv
// Shared RV32I decode constants, EX aluop encoding and the decoded-bundle type
// used by the decode stage.
package id_pkg;

    localparam int DATA_W  = 32;
    localparam int ALUOP_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [ALUOP_W-1:0] {
        EX_NOP, EX_ADD, EX_SUB, EX_SLL, EX_SLT, EX_SLTU, EX_XOR, EX_SRL,
        EX_SRA, EX_OR, EX_AND, EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU,
        EX_SB, EX_SH, EX_SW, EX_BEQ, EX_BNE, EX_BLT, EX_BGE, EX_BLTU,
        EX_BGEU, EX_JAL, EX_JALR, EX_AUIPC
    } aluop_e;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        aluop_e            aluop;
        logic [DATA_W-1:0] offset;
        logic              w_req;
        logic [4:0]        w_addr;
        logic              r1_used;
        logic              r2_used;
        logic              illegal;
    } bundle_t;

    // Register-register / register-immediate op selected by func3 alone.
    function automatic aluop_e alu_f3(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return EX_ADD;
            F3_SLL:  return EX_SLL;
            F3_SLT:  return EX_SLT;
            F3_SLTU: return EX_SLTU;
            F3_XOR:  return EX_XOR;
            F3_SR:   return EX_SRL;
            F3_OR:   return EX_OR;
            default: return EX_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: instruction word to decoded bundle.
module id_decode import id_pkg::*; (
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] pc,
    output bundle_t           dec
);
    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic              ill;
    logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = DATA_W'($signed(inst[31:20]));
    assign imm_s = DATA_W'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = DATA_W'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_j = DATA_W'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign imm_u = DATA_W'($signed({inst[31:12], 12'b0}));
    assign shamt = DATA_W'(inst[24:20]);

    always_comb begin
        dec        = '0;
        ill        = 1'b0;
        dec.pc     = pc;
        dec.w_addr = inst[11:7];
        case (opc)
            OPC_OPIMM: begin
                dec.r1_used = 1'b1;
                dec.w_req   = 1'b1;
                dec.offset  = imm_i;
                dec.aluop   = alu_f3(f3);
                if (f3 == F3_SLL) begin
                    dec.offset = shamt;
                    ill        = (f7 != F7_BASE);
                end else if (f3 == F3_SR) begin
                    dec.offset = shamt;
                    dec.aluop  = (f7 == F7_ALT) ? EX_SRA : EX_SRL;
                    ill        = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OPC_OP: begin
                dec.r1_used = 1'b1;
                dec.r2_used = 1'b1;
                dec.w_req   = 1'b1;
                if (f7 == F7_BASE)                      dec.aluop = alu_f3(f3);
                else if (f7 == F7_ALT && f3 == F3_ADD)  dec.aluop = EX_SUB;
                else if (f7 == F7_ALT && f3 == F3_SR)   dec.aluop = EX_SRA;
                else                                    ill = 1'b1;
            end
            OPC_LOAD: begin
                dec.r1_used = 1'b1;
                dec.w_req   = 1'b1;
                dec.offset  = imm_i;
                case (f3)
                    3'd0:    dec.aluop = EX_LB;
                    3'd1:    dec.aluop = EX_LH;
                    3'd2:    dec.aluop = EX_LW;
                    3'd4:    dec.aluop = EX_LBU;
                    3'd5:    dec.aluop = EX_LHU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.r1_used = 1'b1;
                dec.r2_used = 1'b1;
                dec.offset  = imm_s;
                case (f3)
                    3'd0:    dec.aluop = EX_SB;
                    3'd1:    dec.aluop = EX_SH;
                    3'd2:    dec.aluop = EX_SW;
                    default: ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec.r1_used = 1'b1;
                dec.r2_used = 1'b1;
                dec.offset  = imm_b;
                case (f3)
                    3'd0:    dec.aluop = EX_BEQ;
                    3'd1:    dec.aluop = EX_BNE;
                    3'd4:    dec.aluop = EX_BLT;
                    3'd5:    dec.aluop = EX_BGE;
                    3'd6:    dec.aluop = EX_BLTU;
                    3'd7:    dec.aluop = EX_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec.w_req  = 1'b1;
                dec.offset = imm_j;
                dec.aluop  = EX_JAL;
            end
            OPC_JALR: begin
                dec.r1_used = 1'b1;
                dec.w_req   = 1'b1;
                dec.offset  = imm_i;
                dec.aluop   = EX_JALR;
                ill         = (f3 != 3'd0);
            end
            OPC_LUI: begin
                dec.w_req  = 1'b1;
                dec.offset = imm_u;
                dec.aluop  = EX_OR;
            end
            OPC_AUIPC: begin
                dec.w_req  = 1'b1;
                dec.offset = imm_u;
                dec.aluop  = EX_AUIPC;
            end
            default: ill = 1'b1;
        endcase
        // Illegal words still travel to EX, but must not write or read anything.
        if (ill) begin
            dec.aluop   = EX_NOP;
            dec.offset  = '0;
            dec.w_req   = 1'b0;
            dec.r1_used = 1'b0;
            dec.r2_used = 1'b0;
            dec.illegal = 1'b1;
        end
        if (!dec.w_req) dec.w_addr = '0;
    end

endmodule

// File: rtl/id_pipe_stage.sv
// Decode stage: operand forwarding, load-use hazard stall, registered ID/EX
// bundle with valid/ready on both sides and a saturating stall counter.
module id_pipe_stage import id_pkg::*; #(
    parameter int XLEN  = DATA_W,
    parameter int NFWD  = 2,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    output logic [4:0]           rf_r1_addr,
    output logic [4:0]           rf_r2_addr,
    input  logic [XLEN-1:0]      rf_r1_data,
    input  logic [XLEN-1:0]      rf_r2_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 ld_pending,
    input  logic [4:0]           ld_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [ALUOP_W-1:0]   out_aluop,
    output logic [XLEN-1:0]      out_r1,
    output logic [XLEN-1:0]      out_r2,
    output logic [XLEN-1:0]      out_offset,
    output logic                 out_w_req,
    output logic [4:0]           out_w_addr,
    output logic                 out_illegal,
    output logic [CNT_W-1:0]     stall_cnt
);
    bundle_t         dec;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] op1, op2;
    logic            hazard, slot_free, accept;

    id_decode u_dec (.inst(in_inst), .pc(in_pc), .dec(dec));

    assign rs1        = in_inst[19:15];
    assign rs2        = in_inst[24:20];
    assign rf_r1_addr = rs1;
    assign rf_r2_addr = rs2;

    // Scan oldest to youngest so source 0 overrides everything else.
    function automatic logic [XLEN-1:0] operand(input logic used, input logic [4:0] rs,
                                                input logic [XLEN-1:0] rf, input logic [XLEN-1:0] off);
        logic [XLEN-1:0] v;
        v = rf;
        for (int i = NFWD-1; i >= 0; i--)
            if (fwd_valid[i] && fwd_addr[i*5 +: 5] == rs) v = fwd_data[i*XLEN +: XLEN];
        if (rs == 5'd0) v = '0;
        if (!used)      v = off;
        return v;
    endfunction

    assign op1 = operand(dec.r1_used, rs1, rf_r1_data, dec.offset);
    assign op2 = operand(dec.r2_used, rs2, rf_r2_data, dec.offset);

    assign hazard    = in_valid && ld_pending && (ld_addr != 5'd0) &&
                       ((dec.r1_used && rs1 == ld_addr) || (dec.r2_used && rs2 == ld_addr));
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = rdy && !flush && !hazard && slot_free;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_aluop   <= '0;
            out_r1      <= '0;
            out_r2      <= '0;
            out_offset  <= '0;
            out_w_req   <= 1'b0;
            out_w_addr  <= '0;
            out_illegal <= 1'b0;
            stall_cnt   <= '0;
        end else if (rdy) begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_pc      <= dec.pc;
                out_aluop   <= dec.aluop;
                out_r1      <= op1;
                out_r2      <= op2;
                out_offset  <= dec.offset;
                out_w_req   <= dec.w_req;
                out_w_addr  <= dec.w_addr;
                out_illegal <= dec.illegal;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
            if (!flush && hazard && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Parametrised decode stage with a registered ID/EX output and a valid/ready handshake on both sides. It decodes RV32I, reads operands with priority forwarding from NFWD younger stages, and detects load-use hazards by stalling its input and emitting a bubble. It also supports flush, flags illegal instructions and counts stall cycles. It sits between the IF/ID latch and EX, and replaces the combinational decoder plus external ID/EX register.

## Interface
Parameters:
- XLEN, 32, datapath width (operands, pc, offset)
- NFWD, 2, number of forwarding sources; index 0 = youngest, highest priority
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  kill input and output (branch mispredict)
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid high
- in_pc  in  XLEN  instruction address
- in_inst  in  32  instruction word
- rf_r1_addr, rf_r2_addr  out  5 each  register-file read addresses (rs1, rs2)
- rf_r1_data, rf_r2_data  in  XLEN each  register-file read data, same cycle
- fwd_valid  in  NFWD  source i writes a register
- fwd_addr  in  NFWD*5  destination of source i
- fwd_data  in  NFWD*XLEN  result of source i
- ld_pending  in  1  the instruction now in EX is a load
- ld_addr  in  5  destination of that load
- out_valid  out  1  bundle valid
- out_ready  in  1  EX consumes bundle
- out_pc  out  XLEN
- out_aluop  out  ALUOP_W
- out_r1, out_r2  out  XLEN  operands
- out_offset  out  XLEN  extended immediate
- out_w_req  out  1
- out_w_addr  out  5
- out_illegal  out  1  undecodable instruction
- stall_cnt  out  CNT_W  saturating load-use stall cycle count

## Operation
- Decode follows the existing EX_* encoding:
  - OP-IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI (EX_OR), AUIPC.
  - Immediates are sign-extended to XLEN; shift amounts are zero-extended.
  - B and J immediates have bit 0 = 0.
- Operand source:
  - Used rs: value from the highest-priority fwd source i with fwd_valid[i], fwd_addr[i]==rs and rs!=0; otherwise rf data.
  - rs==0 always yields 0; forwarding is ignored for x0.
  - Unused rs: operand = offset.
- Illegal instruction:
  - Triggers on an unknown opcode, or an unknown func3/func7 combination.
  - Result: aluop EX_NOP, w_req 0, out_illegal 1.
  - The bundle is still passed downstream so EX can trap.
- Hazard: in_valid && ld_pending && ld_addr!=0 && ((rs1 used && rs1==ld_addr) || (rs2 used && rs2==ld_addr)).
- in_ready = rdy && !flush && !hazard && (!out_valid || out_ready).
- Register update, in priority order:
  1. rdy low: hold everything.
  2. flush: out_valid<=0.
  3. Accept (in_valid && in_ready): load bundle, out_valid<=1.
  4. Slot free (!out_valid || out_ready) without accept: out_valid<=0 (bubble).
  5. Otherwise: hold the bundle unchanged.
- Operands are sampled only at accept. A held bundle is never re-read.
- stall_cnt increments when rdy && !flush && hazard, and saturates at all-ones.

## Timing
- Latency: accept in cycle N → out_valid in N+1.
- Throughput: 1 instruction per cycle when there is no hazard and out_ready is high.
- A load-use hazard costs exactly 1 bubble cycle, provided EX advances.
- All outputs are registered except in_ready and rf_r*_addr, which are combinational from in_inst.
- Reset values: out_valid=0, every other registered output =0, stall_cnt=0.
- Reset is asserted asynchronously and may occur mid-bundle; the bundle is discarded.
- flush together with in_valid: the instruction is not accepted and out_valid=0 next cycle.
- out_ready low with out_valid high: the bundle stays stable until the consume cycle.

## Structure
- Package id_pkg holds:
  - opcode and func3 constants
  - EX_* aluop codes and ALUOP_W
  - the decoded-bundle struct (pc, aluop, offset, w_req, w_addr, r1_used, r2_used, illegal)
- Sub-module id_decode: purely combinational, from inst to the bundle struct.
- The top level holds the forwarding mux, hazard logic, output register and counter.

## Test plan
- `addi x5,x0,-1` (0xfff00293), pc 0x100, out_ready=1 → next cycle out_valid=1, aluop EX_ADD, out_r1=0, out_offset=0xFFFFFFFF, w_addr=5.
- `add x3,x1,x2` with fwd0=(x1,0xAA), fwd1=(x1,0xBB), rf x2=7 → out_r1=0xAA, out_r2=7. Repeat with rs1=x0 and fwd0 addr=0 → out_r1=0.
- ld_pending=1, ld_addr=6, then `sub x7,x6,x1` → in_ready=0 for 1 cycle and a bubble (out_valid=0). Next cycle, with ld_pending=0, it is accepted; stall_cnt=1.
- out_ready held low 3 cycles with a bundle → out_valid and all fields stable, in_ready=0. Then out_ready=1 → the next instruction is accepted.
- flush asserted with in_valid and a valid bundle → out_valid=0 next cycle and the input is not consumed. Separately, inst 0x0000007F → out_illegal=1, w_req=0.
- rst_n pulsed low mid-stream, and rdy low for 2 cycles → all outputs 0 after reset; outputs frozen while rdy is low.
